// File: rtl/ext_mem_ctrl_2_if.sv
// Core-side request/response channel of the bank-2 memory controller.
// The core drives requests through the master modport; the controller
// accepts them and returns read data through the slave modport.
interface ext_mem_ctrl_2_if #(
    parameter int DMA_SIZE = 3,
    parameter int DMD_SIZE = 4
);
    logic                req_valid;
    logic                req_ready;
    logic                req_wr;
    logic [DMA_SIZE-1:0] req_addr;
    logic [DMD_SIZE-1:0] req_data;
    logic                resp_valid;
    logic [DMD_SIZE-1:0] resp_data;
    logic                busy;

    modport master (
        output req_valid, req_wr, req_addr, req_data,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_data,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/ext_mem_ctrl_2.sv
// Request sequencer for external memory bank 2: queues single-word
// reads/writes, drives the bank ports from registers, holds a write for one
// cycle when it would overtake a same-address read, and returns read data
// after the bank's fixed read pipeline.
module ext_mem_ctrl_2 #(
    parameter int DMA_SIZE   = 3,
    parameter int DMD_SIZE   = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    ext_mem_ctrl_2_if.slave     core,
    output logic                ps_dm_cslt,
    output logic                ps_dm_wrb,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request queue storage and bookkeeping
    logic                fifo_wr   [FIFO_DEPTH];
    logic [DMA_SIZE-1:0] fifo_addr [FIFO_DEPTH];
    logic [DMD_SIZE-1:0] fifo_data [FIFO_DEPTH];
    ptr_t                wptr;
    ptr_t                rptr;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                empty;
    logic                ready_en;

    // Issue candidate and hazard tracking
    logic                push;
    logic                cand_valid;
    logic                cand_wr;
    logic [DMA_SIZE-1:0] cand_addr;
    logic [DMD_SIZE-1:0] cand_data;
    logic                last_rd_valid;
    logic [DMA_SIZE-1:0] last_rd_addr;
    logic                stall;
    logic                issue;
    logic [3:0]          rd_track;

    assign full           = (count == CNT_W'(FIFO_DEPTH));
    assign empty          = (count == '0);
    assign core.req_ready = ready_en && !full;
    assign push           = core.req_valid && core.req_ready;
    assign cand_valid     = !empty || push;

    // Candidate is the queue head, or the incoming request when the queue is empty
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cand_wr   = core.req_wr;
        cand_addr = core.req_addr;
        cand_data = core.req_data;
        if (!empty) begin
            cand_wr   = fifo_wr[rptr];
            cand_addr = fifo_addr[rptr];
            cand_data = fifo_data[rptr];
        end
    end

    // A write to the address read on the previous edge must wait one cycle
    assign stall = cand_valid && cand_wr && last_rd_valid && (cand_addr == last_rd_addr);
    assign issue = cand_valid && !stall;

    assign core.busy = !empty || ps_dm_cslt || (|rd_track);

    // Queue storage: written on every accepted request, including bypassed ones
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the pointers and count alone define what is valid.
        if (push) begin
            fifo_wr[wptr]   <= core.req_wr;
            fifo_addr[wptr] <= core.req_addr;
            fifo_data[wptr] <= core.req_data;
        end
    end

    // Queue pointers, occupancy, and the post-reset ready enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wptr <= next_ptr(wptr);
            if (issue) rptr <= next_ptr(rptr);
            if (push && !issue) begin
                count <= count + 1'b1;
            end else if (!push && issue) begin
                count <= count - 1'b1;
            end
        end
    end

    // Registered bank ports: load on issue, idle encoding otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_dm_cslt <= 1'b0;
            ps_dm_wrb  <= 1'b0;
            dg_dm_add  <= '0;
            bc_dt      <= '0;
        end else if (issue) begin
            ps_dm_cslt <= 1'b1;
            ps_dm_wrb  <= cand_wr;
            dg_dm_add  <= cand_addr;
            bc_dt      <= cand_wr ? cand_data : '0;
        end else begin
            ps_dm_cslt <= 1'b0;
            ps_dm_wrb  <= 1'b0;
        end
    end

    // Remember the address of a read issued on this edge for the hazard check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd_valid <= 1'b0;
            last_rd_addr  <= '0;
        end else begin
            last_rd_valid <= issue && !cand_wr;
            if (issue && !cand_wr) last_rd_addr <= cand_addr;
        end
    end

    // Follow each read through the bank pipeline and capture its data on exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_track        <= '0;
            core.resp_valid <= 1'b0;
            core.resp_data  <= '0;
        end else begin
            rd_track        <= {rd_track[2:0], issue && !cand_wr};
            core.resp_valid <= rd_track[3];
            if (rd_track[3]) core.resp_data <= dm_bc_dt;
        end
    end
endmodule
